// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder scan controller: FSM encoding and select width.
package decoder_scan_pkg;

    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(7);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_dwell_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than underflowing.
module dwell_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sweeps a 3-to-8 decoder select through 0..7, holding each value dwell+1 cycles,
// either once (with a done pulse) or continuously until stop.
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    // Request semantics: start is a level request honoured only in IDLE when stop
    // is low; stop aborts from SCAN on the next edge and wins over start in IDLE.
    // mode and dwell are captured with start and ignored for the rest of the sweep.

    state_t               state, state_d;
    logic [SEL_W-1:0]     sel, sel_d;
    logic                 mode_q, mode_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 en_d, busy_d, done_d;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [DWELL_W-1:0]   cnt_load_val, cnt;

    dwell_counter #(.W(DWELL_W)) u_dwell_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state;
        sel_d        = sel;
        mode_d       = mode_q;
        dwell_d      = dwell_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = dwell_q;

        case (state)
            IDLE: begin
                sel_d = '0;
                if (start && !stop) begin
                    state_d      = SCAN;
                    mode_d       = mode;
                    dwell_d      = dwell;
                    cnt_load     = 1'b1;
                    cnt_load_val = dwell;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    sel_d   = '0;
                end else if (cnt_zero) begin
                    if (sel != SEL_LAST) begin
                        sel_d    = sel + SEL_W'(1);
                        cnt_load = 1'b1;
                    end else if (mode_q) begin
                        sel_d    = '0;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = FINISH;
                        sel_d   = '0;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                sel_d   = '0;
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        en_d   = (state_d == SCAN);
        busy_d = (state_d == SCAN);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            mode_q  <= 1'b0;
            dwell_q <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            sel     <= sel_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            en      <= en_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign {a, b, c} = sel;
    assign dbg_state = state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl against a cycle-index reference model.
module tb_decoder_scan_ctrl;

    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               mode = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               a, b, c, en, busy, done;
    logic [1:0]         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
        .a         (a),
        .b         (b),
        .c         (c),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Expected {en,busy,done,sel} k cycles after the start edge.
    function automatic logic [5:0] model_out(input int d, input bit m, input int k);
        int len = 8 * (d + 1);
        logic [2:0] s;
        if (m || k < len) begin
            s = 3'((k / (d + 1)) % 8);
            return {3'b110, s};
        end
        if (k == len) return 6'b001_000;
        return 6'b000_000;
    endfunction

    function automatic logic [5:0] obs();
        return {en, busy, done, a, b, c};
    endfunction

    // Start a sweep from IDLE and check ncyc cycles; stop is raised in cycle stop_k
    // (negative = never). With noise, dwell/mode/start are scrambled while scanning.
    task automatic sweep(input int d, input bit m, input int ncyc, input int stop_k,
                         input bit noise, input string tag);
        logic [5:0] exp_q[$];
        logic [5:0] e;
        int len = 8 * (d + 1);
        for (int k = 0; k < ncyc; k++)
            exp_q.push_back((stop_k >= 0 && k > stop_k) ? 6'b0 : model_out(d, m, k));
        start = 1'b1;
        stop  = 1'b0;
        dwell = DWELL_W'(d);
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: en/busy/done/sel got %b expected %b",
                         tag, k, obs(), e);
            end
            stop = (k == stop_k);
            if (noise && (stop_k < 0 || k < stop_k) && (m || k <= len)) begin
                dwell = (k % 2 == 1) ? DWELL_W'(7) : DWELL_W'($urandom);
                mode  = 1'($urandom);
                start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (obs() !== 6'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: outputs %b state %0d expected outputs 000000 state 0",
                     tag, obs(), dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dwell = DWELL_W'($urandom);
            mode  = 1'($urandom);
            stop  = 1'($urandom);
            @(negedge clk);
            check_idle("idle_no_start");
        end
        stop = 1'b0;
    endtask

    task automatic test_single_sweep();
        sweep(0, 1'b0, 11, -1, 1'b0, "dwell0_single");
        sweep(3, 1'b0, 35, -1, 1'b0, "dwell3_single");
    endtask

    task automatic test_continuous();
        sweep(1, 1'b1, 22, 19, 1'b0, "dwell1_cont");
        sweep(0, 1'b1, 20, 17, 1'b1, "dwell0_cont_noise");
    endtask

    task automatic test_stop();
        for (int i = 0; i < 3; i++) begin
            int d = $urandom_range(0, 5);
            int sk = 5 * (d + 1) + $urandom_range(0, d);
            sweep(d, 1'b0, sk + 4, sk, 1'b1, "stop_at_sel5");
        end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1;
        stop  = 1'b1;
        dwell = DWELL_W'($urandom);
        @(negedge clk);
        check_idle("start_and_stop");
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("start_and_stop_after");
        end
    endtask

    task automatic test_reset_mid();
        int d;
        sweep(2, 1'b0, 10, -1, 1'b0, "pre_reset_sel3");
        #2 rst = 1'b1;
        #1 check_idle("async_reset_mid");
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_released");
        d = $urandom_range(0, 4);
        sweep(d, 1'b0, 8 * (d + 1) + 2, -1, 1'b0, "after_reset");
    endtask

    task automatic test_mid_sweep_changes();
        sweep(2, 1'b0, 27, -1, 1'b1, "dwell_change");
        sweep(1, 1'b0, 18, -1, 1'b1, "mode_change");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            int d = $urandom_range(0, 15);
            sweep(d, 1'b0, 8 * (d + 1) + 2, -1, 1'(i), "back_to_back");
        end
        begin
            int d = $urandom_range(0, 6);
            int sk = $urandom_range(1, 120);
            sweep(d, 1'b1, sk + 3, sk, 1'b1, "rand_cont_stop");
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_continuous();
        test_stop();
        test_start_stop_idle();
        test_reset_mid();
        test_mid_sweep_changes();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
